// File: rtl/rv_pkg.sv
// Shared RV32I fetch-side definitions: default widths, redirect priority codes
// and the PC generator FSM state constants.
package rv_pkg;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] BOOT_ADDRESS_DEFAULT = 32'h0000_0000;

  // Numeric order is the redirect priority; NONE marks an empty pending slot.
  typedef enum logic [2:0] {
    REDIR_NONE   = 3'd0,
    REDIR_SEQ    = 3'd1,
    REDIR_BRANCH = 3'd2,
    REDIR_MRET   = 3'd3,
    REDIR_TRAP   = 3'd4
  } redir_t;

  typedef logic [1:0] state_t;
  localparam state_t BOOT  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t STALL = 2'd2;

endpackage

// File: rtl/trap_target_calc.sv
// Combinational mtvec target generation: direct mode, or vectored offset for
// interrupts. Shared with the CSR unit.
module trap_target_calc
  import rv_pkg::*;
#(
  parameter int XLEN            = XLEN_DEFAULT,
  parameter int CAUSE_W         = 5,
  parameter int VEC_STRIDE_LOG2 = 2
) (
  input  logic [XLEN-1:0]    trap_base_in,
  input  logic               trap_vectored_in,
  input  logic               trap_is_irq_in,
  input  logic [CAUSE_W-1:0] trap_cause_in,
  output logic [XLEN-1:0]    trap_target_out
);

  logic [XLEN-1:0] base_aligned;
  logic [XLEN-1:0] vec_offset;

  assign base_aligned    = {trap_base_in[XLEN-1:2], 2'b00};
  assign vec_offset      = XLEN'(trap_cause_in) << VEC_STRIDE_LOG2;
  // Exceptions always use the base even in vectored mode; the add wraps.
  assign trap_target_out = (trap_vectored_in && trap_is_irq_in) ? base_aligned + vec_offset
                                                                : base_aligned;

endmodule

// File: rtl/pc_gen_unit.sv
// Registered fetch-address generator with bus-ready handshake and a 1-deep
// redirect buffer that holds redirects arriving while the bus is stalled.
module pc_gen_unit
  import rv_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] BOOT_ADDRESS    = XLEN'(BOOT_ADDRESS_DEFAULT),
  parameter bit              C_EXT           = 1'b0,
  parameter int              VEC_STRIDE_LOG2 = 2,
  parameter int              CAUSE_W         = 5
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               ahb_ready_in,
  input  logic               branch_taken_in,
  input  logic [XLEN-1:1]    iaddr_in,
  input  logic               trap_in,
  input  logic [XLEN-1:0]    trap_base_in,
  input  logic               trap_vectored_in,
  input  logic               trap_is_irq_in,
  input  logic [CAUSE_W-1:0] trap_cause_in,
  input  logic               mret_in,
  input  logic [XLEN-1:0]    epc_in,
  output logic [XLEN-1:0]    i_addr_out,
  output logic               i_valid_out,
  output logic [XLEN-1:0]    pc_out,
  output logic [XLEN-1:0]    pc_plus_4_out,
  output logic               misaligned_instr_logic_out,
  output logic               redirect_pending_out
);

  state_t          state_q;
  logic [XLEN-1:0] i_addr_q;
  logic [XLEN-1:0] pc_q;
  logic            i_valid_q;
  logic            misaligned_q;
  redir_t          pend_src_q;
  logic [XLEN-1:0] pend_addr_q;

  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] branch_target;
  logic            branch_misaligned;
  redir_t          live_src;
  logic [XLEN-1:0] live_addr;
  logic [XLEN-1:0] next_addr;

  trap_target_calc #(
    .XLEN            (XLEN),
    .CAUSE_W         (CAUSE_W),
    .VEC_STRIDE_LOG2 (VEC_STRIDE_LOG2)
  ) u_trap_target_calc (
    .trap_base_in     (trap_base_in),
    .trap_vectored_in (trap_vectored_in),
    .trap_is_irq_in   (trap_is_irq_in),
    .trap_cause_in    (trap_cause_in),
    .trap_target_out  (trap_target)
  );

  assign branch_target     = {iaddr_in, 1'b0};
  assign branch_misaligned = branch_taken_in && branch_target[1] && !C_EXT;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    live_src  = REDIR_SEQ;
    live_addr = i_addr_q + XLEN'(4);
    if (trap_in) begin
      live_src  = REDIR_TRAP;
      live_addr = trap_target;
    end else if (mret_in) begin
      live_src  = REDIR_MRET;
      live_addr = epc_in;
    end else if (branch_taken_in && !branch_misaligned) begin
      live_src  = REDIR_BRANCH;
      live_addr = branch_target;
    end
  end

  // An empty slot (NONE) loses to everything; on a priority tie the buffered
  // redirect, which arrived first, is kept.
  assign next_addr = (pend_src_q >= live_src) ? pend_addr_q : live_addr;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= BOOT;
      i_addr_q     <= BOOT_ADDRESS;
      pc_q         <= BOOT_ADDRESS;
      i_valid_q    <= 1'b0;
      misaligned_q <= 1'b0;
      pend_src_q   <= REDIR_NONE;
      pend_addr_q  <= '0;
    end else begin
      misaligned_q <= i_valid_q && branch_misaligned && !trap_in && !mret_in;
      case (state_q)
        BOOT: begin
          i_valid_q <= 1'b1;
          state_q   <= RUN;
        end
        default: begin
          if (ahb_ready_in) begin
            pc_q       <= i_addr_q;
            i_addr_q   <= next_addr;
            pend_src_q <= REDIR_NONE;
            state_q    <= RUN;
          end else begin
            state_q <= STALL;
            if (live_src != REDIR_SEQ && live_src >= pend_src_q) begin
              pend_src_q  <= live_src;
              pend_addr_q <= live_addr;
            end
          end
        end
      endcase
    end
  end

  assign i_addr_out                 = i_addr_q;
  assign i_valid_out                = i_valid_q;
  assign pc_out                     = pc_q;
  assign pc_plus_4_out              = pc_q + XLEN'(4);
  assign misaligned_instr_logic_out = misaligned_q;
  assign redirect_pending_out       = (pend_src_q != REDIR_NONE);

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench: two instances (C_EXT=0 and C_EXT=1) on shared stimulus,
// compared every cycle against a behavioural fetch model.
module tb_pc_gen_unit;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        ahb_ready_in = 1'b0;
  logic        branch_taken_in = 1'b0;
  logic [31:1] iaddr_in = '0;
  logic        trap_in = 1'b0;
  logic [31:0] trap_base_in = '0;
  logic        trap_vectored_in = 1'b0;
  logic        trap_is_irq_in = 1'b0;
  logic [4:0]  trap_cause_in = '0;
  logic        mret_in = 1'b0;
  logic [31:0] epc_in = '0;

  logic [1:0][31:0] i_addr_o, pc_o, pc4_o;
  logic [1:0]       valid_o, mis_o, pend_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model state, one slot per instance (index = C_EXT).
  logic [31:0] m_iaddr[2], m_pc[2], m_pend_addr[2];
  int          m_pend_prio[2];
  bit          m_valid[2], m_mis[2], m_boot[2];

  always #5 clk_in = ~clk_in;

  pc_gen_unit #(.C_EXT(1'b0)) u_dut0 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .ahb_ready_in(ahb_ready_in),
    .branch_taken_in(branch_taken_in), .iaddr_in(iaddr_in), .trap_in(trap_in),
    .trap_base_in(trap_base_in), .trap_vectored_in(trap_vectored_in),
    .trap_is_irq_in(trap_is_irq_in), .trap_cause_in(trap_cause_in),
    .mret_in(mret_in), .epc_in(epc_in),
    .i_addr_out(i_addr_o[0]), .i_valid_out(valid_o[0]), .pc_out(pc_o[0]),
    .pc_plus_4_out(pc4_o[0]), .misaligned_instr_logic_out(mis_o[0]),
    .redirect_pending_out(pend_o[0])
  );

  pc_gen_unit #(.C_EXT(1'b1)) u_dut1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .ahb_ready_in(ahb_ready_in),
    .branch_taken_in(branch_taken_in), .iaddr_in(iaddr_in), .trap_in(trap_in),
    .trap_base_in(trap_base_in), .trap_vectored_in(trap_vectored_in),
    .trap_is_irq_in(trap_is_irq_in), .trap_cause_in(trap_cause_in),
    .mret_in(mret_in), .epc_in(epc_in),
    .i_addr_out(i_addr_o[1]), .i_valid_out(valid_o[1]), .pc_out(pc_o[1]),
    .pc_plus_4_out(pc4_o[1]), .misaligned_instr_logic_out(mis_o[1]),
    .redirect_pending_out(pend_o[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_iaddr[k] = 32'h0; m_pc[k] = 32'h0; m_pend_addr[k] = 32'h0;
      m_pend_prio[k] = 0; m_valid[k] = 0; m_mis[k] = 0; m_boot[k] = 1;
    end
  endtask

  // Priorities: 0 none/sequential, 1 branch, 2 mret, 3 trap.
  task automatic model_step(input int k);
    int          prio;
    logic [31:0] addr, tgt, base;
    bit          bad;
    if (m_boot[k]) begin
      m_boot[k] = 0; m_valid[k] = 1; m_mis[k] = 0;
      return;
    end
    prio = 0;
    addr = 32'h0;
    tgt  = {iaddr_in, 1'b0};
    base = trap_base_in & 32'hFFFF_FFFC;
    bad  = branch_taken_in && tgt[1] && (k == 0);
    if (trap_in) begin
      prio = 3;
      addr = (trap_vectored_in && trap_is_irq_in) ? base + 32'(trap_cause_in) * 4 : base;
    end else if (mret_in) begin
      prio = 2; addr = epc_in;
    end else if (branch_taken_in && !bad) begin
      prio = 1; addr = tgt;
    end
    m_mis[k] = bad && !trap_in && !mret_in;
    if (ahb_ready_in) begin
      m_pc[k] = m_iaddr[k];
      if (m_pend_prio[k] > 0 && m_pend_prio[k] >= prio) m_iaddr[k] = m_pend_addr[k];
      else if (prio > 0)                                m_iaddr[k] = addr;
      else                                              m_iaddr[k] = m_iaddr[k] + 32'd4;
      m_pend_prio[k] = 0;
    end else if (prio > 0 && prio >= m_pend_prio[k]) begin
      m_pend_prio[k] = prio;
      m_pend_addr[k] = addr;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("i_addr[%0d]", k),     i_addr_o[k],       m_iaddr[k]);
      check($sformatf("i_valid[%0d]", k),    32'(valid_o[k]),   32'(m_valid[k]));
      check($sformatf("pc[%0d]", k),         pc_o[k],           m_pc[k]);
      check($sformatf("pc_plus_4[%0d]", k),  pc4_o[k],          m_pc[k] + 32'd4);
      check($sformatf("misaligned[%0d]", k), 32'(mis_o[k]),     32'(m_mis[k]));
      check($sformatf("pending[%0d]", k),    32'(pend_o[k]),    32'(m_pend_prio[k] != 0));
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic idle();
    branch_taken_in = 0; trap_in = 0; mret_in = 0;
  endtask

  initial begin
    model_reset();
    ahb_ready_in = 1;
    #1 rst_n_in = 0;
    #10 compare_all();
    rst_n_in = 1;

    // Boot then sequential 4, 8, C with pc lagging.
    tick(); check("boot_addr", i_addr_o[0], 32'h0);
    tick(); tick(); tick(); check("seq_c", i_addr_o[0], 32'hC);
    check("pc_lag", pc_o[0], 32'h8);

    // Branch while ready, then a branch buffered across a 3-cycle stall.
    branch_taken_in = 1; iaddr_in = 31'h40;
    tick(); idle(); check("branch_80", i_addr_o[0], 32'h80);
    ahb_ready_in = 0; branch_taken_in = 1; iaddr_in = 31'h100;
    tick(); idle(); tick(); tick();
    check("stall_pend", 32'(pend_o[0]), 32'd1);
    check("stall_hold", i_addr_o[0], 32'h80);
    ahb_ready_in = 1;
    tick(); check("stall_release", i_addr_o[0], 32'h200);

    // Vectored interrupt vs exception in vectored mode.
    trap_in = 1; trap_base_in = 32'h1000; trap_cause_in = 5'd7;
    trap_vectored_in = 1; trap_is_irq_in = 1;
    tick(); check("vec_irq", i_addr_o[0], 32'h101C);
    trap_is_irq_in = 0;
    tick(); check("vec_exc", i_addr_o[0], 32'h1000);
    idle(); trap_vectored_in = 0;

    // Misaligned branch target: dropped with C_EXT=0, taken with C_EXT=1.
    branch_taken_in = 1; iaddr_in = 31'h41;
    tick(); idle();
    check("mis_pulse0", 32'(mis_o[0]), 32'd1);
    check("mis_seq0", i_addr_o[0], 32'h1004);
    check("mis_cext1", i_addr_o[1], 32'h82);
    tick(); check("mis_clear0", 32'(mis_o[0]), 32'd0);

    // Stall: branch then trap -> trap; trap then branch -> trap kept.
    ahb_ready_in = 0; branch_taken_in = 1; iaddr_in = 31'h200;
    tick(); idle(); trap_in = 1; trap_base_in = 32'h2003;
    tick(); idle(); ahb_ready_in = 1;
    tick(); check("stall_br_trap", i_addr_o[0], 32'h2000);
    ahb_ready_in = 0; trap_in = 1; trap_base_in = 32'h3000;
    tick(); idle(); branch_taken_in = 1; iaddr_in = 31'h300;
    tick(); idle(); ahb_ready_in = 1;
    tick(); check("stall_trap_br", i_addr_o[0], 32'h3000);

    // Simultaneous trap and mret.
    trap_in = 1; trap_base_in = 32'h4000; mret_in = 1; epc_in = 32'h5000;
    tick(); idle(); check("trap_over_mret", i_addr_o[0], 32'h4000);

    // Sequential wrap at the top of the address space.
    branch_taken_in = 1; iaddr_in = 31'h7FFF_FFFE;
    tick(); idle(); check("wrap_top", i_addr_o[0], 32'hFFFF_FFFC);
    tick(); check("wrap_zero", i_addr_o[0], 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      ahb_ready_in     = ($urandom_range(0, 3) != 0);
      branch_taken_in  = ($urandom_range(0, 3) == 0);
      iaddr_in         = 31'($urandom);
      trap_in          = ($urandom_range(0, 15) == 0);
      trap_base_in     = $urandom;
      trap_vectored_in = 1'($urandom);
      trap_is_irq_in   = 1'($urandom);
      trap_cause_in    = 5'($urandom);
      mret_in          = ($urandom_range(0, 15) == 0);
      epc_in           = $urandom;
      tick();
    end
    idle();

    // Reset asserted mid-stall with a pending redirect.
    ahb_ready_in = 0; branch_taken_in = 1; iaddr_in = 31'h50;
    tick(); idle();
    check("pre_reset_pend", 32'(pend_o[0]), 32'd1);
    #2 rst_n_in = 0;
    model_reset();
    #1 compare_all();
    @(negedge clk_in);
    rst_n_in = 1; ahb_ready_in = 1;
    tick(); tick();
    check("post_reset_seq", i_addr_o[0], 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
